// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register offsets and limits shared by the interrupt aggregator.
package irq_ctrl_pkg;
  localparam int NSRC_MAX = 31;
  localparam logic [4:0] IRQ_PENDING = 5'h00;
  localparam logic [4:0] IRQ_ENABLE  = 5'h04;
  localparam logic [4:0] IRQ_MODE    = 5'h08;
  localparam logic [4:0] IRQ_CLAIM   = 5'h0C;
  localparam logic [4:0] IRQ_RAW     = 5'h10;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: returns id+1 of the lowest set request bit, or 0 when none is set.
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [4:0]   id
);
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--) id = req[i] ? 5'(i + 1) : id;
  end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: latches edge/level interrupt requests, masks them and exposes them
// over a zero-wait-state AHB3-Lite slave with a lowest-index claim register.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                    NSRC       = 8,
  parameter int                    HADDR_SIZE = 32,
  parameter logic [HADDR_SIZE-1:0] BASE       = '0,
  parameter int                    HDATA_SIZE = 32
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys_n,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  input  logic [NSRC-1:0]       irq_src,
  output logic                  irq_o
);
  logic [NSRC-1:0] pending, enable, mode, src_q, claim_clr, w1c, clr;
  logic            dp_valid, dp_write, rd, wr, claim;
  logic [4:0]      dp_off, id;
  logic            unused;

  // Decode is offset-only; BASE and upper address bits are resolved by bus_mux.
  assign unused = ^{HADDR[HADDR_SIZE-1:5], HSIZE, HTRANS[0], HWDATA[HDATA_SIZE-1:NSRC], BASE};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign rd        = dp_valid & ~dp_write;
  assign wr        = dp_valid & dp_write;

  irq_prio_enc #(.N(NSRC)) u_enc (.req(pending & enable), .id(id));

  assign claim = rd && dp_off == IRQ_CLAIM && id != 5'd0;
  assign w1c   = (wr && dp_off == IRQ_PENDING) ? HWDATA[NSRC-1:0] : '0;
  assign clr   = w1c | claim_clr;

  always_comb begin
    claim_clr = '0;
    for (int i = 0; i < NSRC; i++) claim_clr[i] = claim && id == 5'(i + 1);
  end

  assign HRDATA = !rd                  ? '0 :
                  dp_off == IRQ_PENDING ? HDATA_SIZE'(pending) :
                  dp_off == IRQ_ENABLE  ? HDATA_SIZE'(enable) :
                  dp_off == IRQ_MODE    ? HDATA_SIZE'(mode) :
                  dp_off == IRQ_CLAIM   ? HDATA_SIZE'(id) :
                  dp_off == IRQ_RAW     ? HDATA_SIZE'(irq_src) : '0;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_off   <= '0;
      src_q    <= '0;
      pending  <= '0;
      enable   <= '0;
      mode     <= '0;
      irq_o    <= 1'b0;
    end else begin
      if (HREADY) begin
        dp_valid <= HSEL & HTRANS[1];
        dp_write <= HWRITE;
        dp_off   <= HADDR[4:0];
      end
      src_q   <= irq_src;
      // Edge bits: new edge beats any clear in the same cycle; level bits track the source.
      pending <= (mode & ((irq_src & ~src_q) | (pending & ~clr))) | (~mode & irq_src);
      if (wr && dp_off == IRQ_ENABLE) enable <= HWDATA[NSRC-1:0];
      if (wr && dp_off == IRQ_MODE) mode <= HWDATA[NSRC-1:0];
      irq_o   <= |(pending & enable);
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scoreboard bench for irq_ctrl over its AHB slave port.
module tb_irq_ctrl;
  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] hwdata = '0;
  logic        hready = 1'b1;
  logic [31:0] hrdata;
  logic        hreadyout, hresp, irq;
  logic [7:0]  irq_src = '0;
  sb_t         sb[$];
  sb_t         ent;
  int          passed = 0;
  int          total = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.NSRC(8)) dut (
    .clk_sys(clk), .rst_sys_n(rst_n), .HSEL(hsel), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready), .HRDATA(hrdata),
    .HREADYOUT(hreadyout), .HRESP(hresp), .irq_src(irq_src), .irq_o(irq)
  );

  task automatic check(input string t, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", t, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [4:0] a, input logic w);
    hsel = 1'b1; htrans = 2'b10; haddr = {27'd0, a}; hwrite = w;
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    tick();
    addr_phase(a, 1'b1);
    tick();
    idle();
    hwdata = d;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string t);
    tick();
    addr_phase(a, 1'b0);
    sb.push_back('{t, e});
    tick();
    idle();
    ent = sb.pop_front();
    check(ent.tag, hrdata, ent.exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
    rst_n = 1'b1;
    rd(5'h00, 32'h0, "rst_pending");
    rd(5'h04, 32'h0, "rst_enable");
    rd(5'h08, 32'h0, "rst_mode");
    rd(5'h0C, 32'h0, "rst_claim");
    rd(5'h10, 32'h0, "rst_raw");
    // edge flow
    wr(5'h08, 32'hFF);
    wr(5'h04, 32'h05);
    check("wr_dphase_hrdata", hrdata, 32'd0);
    tick();
    irq_src = 8'h04;
    check("edge_irq_pre", {31'd0, irq}, 32'd0);
    tick();
    irq_src = 8'h00;
    check("edge_irq_1", {31'd0, irq}, 32'd0);
    tick();
    check("edge_irq_2", {31'd0, irq}, 32'd1);
    rd(5'h00, 32'h04, "edge_pending");
    rd(5'h08, 32'hFF, "edge_mode");
    rd(5'h0C, 32'd3, "edge_claim");
    tick();
    check("claim_irq_hold", {31'd0, irq}, 32'd1);
    tick();
    check("claim_irq_fall", {31'd0, irq}, 32'd0);
    rd(5'h00, 32'h00, "claim_pending");
    // priority
    wr(5'h04, 32'h12);
    tick();
    irq_src = 8'h12;
    tick();
    irq_src = 8'h00;
    rd(5'h0C, 32'd2, "prio_claim_a");
    rd(5'h0C, 32'd5, "prio_claim_b");
    rd(5'h0C, 32'd0, "prio_claim_c");
    // level mode
    wr(5'h08, 32'h00);
    wr(5'h04, 32'h01);
    tick();
    irq_src = 8'h01;
    tick();
    tick();
    check("lvl_irq_on", {31'd0, irq}, 32'd1);
    wr(5'h00, 32'h01);
    rd(5'h00, 32'h01, "lvl_w1c_pending");
    rd(5'h0C, 32'd1, "lvl_claim");
    rd(5'h00, 32'h01, "lvl_claim_pending");
    check("lvl_irq_kept", {31'd0, irq}, 32'd1);
    irq_src = 8'h00;
    tick();
    check("lvl_irq_drop1", {31'd0, irq}, 32'd1);
    tick();
    check("lvl_irq_drop2", {31'd0, irq}, 32'd0);
    // set/clear collision on an edge bit
    wr(5'h08, 32'h08);
    wr(5'h04, 32'h00);
    tick();
    irq_src = 8'h08;
    tick();
    irq_src = 8'h00;
    tick();
    wr(5'h00, 32'h08);
    irq_src = 8'h08;
    tick();
    irq_src = 8'h00;
    rd(5'h00, 32'h08, "collide_pending");
    wr(5'h00, 32'h08);
    rd(5'h00, 32'h00, "w1c_pending");
    // bus corners
    wr(5'h04, 32'hFFFFFFFF);
    rd(5'h04, 32'hFF, "enable_mask");
    rd(5'h14, 32'h0, "bad_offset");
    irq_src = 8'hA5;
    rd(5'h10, 32'hA5, "raw");
    irq_src = 8'h00;
    wr(5'h0C, 32'h1F);
    rd(5'h0C, 32'h0, "claim_wr_ignored");
    tick();
    addr_phase(5'h04, 1'b1);
    tick();
    hwdata = 32'h5A;
    addr_phase(5'h04, 1'b0);
    sb.push_back('{"b2b_enable", 32'h5A});
    check("b2b_ready", {31'd0, hreadyout}, 32'd1);
    tick();
    idle();
    ent = sb.pop_front();
    check(ent.tag, hrdata, ent.exp);
    check("hresp", {31'd0, hresp}, 32'd0);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
